// File: rtl/pipe_hazard_if.sv
// Hazard-unit bus: ID-stage instruction fields in, pipeline control and
// forwarding selects, tracked tags and debug counters out.
interface pipe_hazard_if #(
  parameter int REG_BITS = 5,
  parameter int CNT_W    = 16
);
  logic                id_valid;
  logic [REG_BITS-1:0] id_rn;
  logic [REG_BITS-1:0] id_rm;
  logic                id_uses_rn;
  logic                id_uses_rm;
  logic [REG_BITS-1:0] id_rd;
  logic                id_regwrite;
  logic                id_memread;

  logic                stall;
  logic                freeze;
  logic [1:0]          fwd_a;
  logic [1:0]          fwd_b;
  logic [REG_BITS-1:0] ex_rd;
  logic [REG_BITS-1:0] mem_rd;
  logic [REG_BITS-1:0] wb_rd;
  logic [CNT_W-1:0]    stall_cnt;
  logic [CNT_W-1:0]    freeze_cnt;

  modport master (
    output id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_regwrite, id_memread,
    input  stall, freeze, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, stall_cnt, freeze_cnt
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_uses_rn, id_uses_rm, id_rd, id_regwrite, id_memread,
    output stall, freeze, fwd_a, fwd_b, ex_rd, mem_rd, wb_rd, stall_cnt, freeze_cnt
  );
endinterface

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: tracks destination tags through EX/MEM/WB,
// drives ALU operand forwarding, load-use bubbles and a freeze for slow loads.
module pipe_hazard_unit #(
  parameter int REG_BITS = 5,
  parameter int ZERO_REG = 31,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input logic          clk,
  input logic          Reset,
  pipe_hazard_if.slave hz
);
  localparam logic [REG_BITS-1:0] ZR        = REG_BITS'(ZERO_REG);
  localparam logic [2:0]          LAST_WAIT = 3'(LOAD_LAT - 1);
  localparam bit                  MULTI_CYC = (LOAD_LAT > 1);

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic [REG_BITS-1:0] rn;
    logic [REG_BITS-1:0] rm;
    logic                regwrite;
    logic                memread;
    logic                uses_rn;
    logic                uses_rm;
  } ex_tag_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
    logic                memread;
  } mem_tag_t;

  typedef struct packed {
    logic [REG_BITS-1:0] rd;
    logic                regwrite;
  } wb_tag_t;

  typedef enum logic { ST_IDLE, ST_WAIT } state_t;

  localparam ex_tag_t EX_BUBBLE = '{rd: ZR, rn: ZR, rm: ZR, regwrite: 1'b0,
                                    memread: 1'b0, uses_rn: 1'b0, uses_rm: 1'b0};
  localparam mem_tag_t MEM_BUBBLE = '{rd: ZR, regwrite: 1'b0, memread: 1'b0};
  localparam wb_tag_t  WB_BUBBLE  = '{rd: ZR, regwrite: 1'b0};

  // Event counters hold at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Newest producer wins; a load still in MEM has no data to forward yet.
  function automatic logic [1:0] fwd_sel(input logic uses, input logic [REG_BITS-1:0] src,
                                         input mem_tag_t m, input wb_tag_t w);
    logic [1:0] sel;
    sel = 2'b00;
    if (uses && m.regwrite && !m.memread && (m.rd != ZR) && (m.rd == src)) begin
      sel = 2'b10;
    end else if (uses && w.regwrite && (w.rd != ZR) && (w.rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  ex_tag_t          ex_q, ex_d;
  mem_tag_t         mem_q, mem_d;
  wb_tag_t          wb_q, wb_d;
  state_t           state_q, state_d;
  logic [2:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  logic freeze;
  logic load_use;
  logic stall;

  // In WAIT the counter never reaches LOAD_LAT, so freeze spans the whole wait.
  assign freeze   = (state_q == ST_WAIT) && ({1'b0, wait_cnt_q} < 4'(LOAD_LAT));
  assign load_use = ex_q.memread && ex_q.regwrite && (ex_q.rd != ZR) &&
                    ((hz.id_uses_rn && (hz.id_rn == ex_q.rd)) ||
                     (hz.id_uses_rm && (hz.id_rm == ex_q.rd)));
  assign stall    = !freeze && hz.id_valid && load_use;

  assign hz.stall      = stall;
  assign hz.freeze     = freeze;
  assign hz.fwd_a      = fwd_sel(ex_q.uses_rn, ex_q.rn, mem_q, wb_q);
  assign hz.fwd_b      = fwd_sel(ex_q.uses_rm, ex_q.rm, mem_q, wb_q);
  assign hz.ex_rd      = ex_q.rd;
  assign hz.mem_rd     = mem_q.rd;
  assign hz.wb_rd      = wb_q.rd;
  assign hz.stall_cnt  = stall_cnt_q;
  assign hz.freeze_cnt = freeze_cnt_q;

  // Next tag stages, memory-wait FSM and counters.
  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    stall_cnt_d  = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
    freeze_cnt_d = freeze ? sat_inc(freeze_cnt_q) : freeze_cnt_q;

    // ID -> EX -> MEM -> WB boundary: the whole tag pipe moves unless frozen.
    if (!freeze) begin
      wb_d  = '{rd: mem_q.rd, regwrite: mem_q.regwrite};
      mem_d = '{rd: ex_q.rd, regwrite: ex_q.regwrite, memread: ex_q.memread};
      if (stall || !hz.id_valid) begin
        ex_d = EX_BUBBLE;
      end else begin
        ex_d = '{rd: hz.id_rd, rn: hz.id_rn, rm: hz.id_rm, regwrite: hz.id_regwrite,
                 memread: hz.id_memread, uses_rn: hz.id_uses_rn, uses_rm: hz.id_uses_rm};
      end
    end

    // The wait starts on the edge that moves a load into MEM.
    case (state_q)
      ST_IDLE: begin
        if (MULTI_CYC && !freeze && ex_q.memread) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 3'd1;
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == LAST_WAIT) begin
          state_d    = ST_IDLE;
          wait_cnt_d = 3'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 3'd1;
        end
      end
    endcase
  end

  // State registers; reset overrides freeze and discards any frozen load.
  always_ff @(posedge clk) begin
    if (Reset) begin
      ex_q         <= EX_BUBBLE;
      mem_q        <= MEM_BUBBLE;
      wb_q         <= WB_BUBBLE;
      state_q      <= ST_IDLE;
      wait_cnt_q   <= 3'd0;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Bench for pipe_hazard_unit: instance 0 uses single-cycle loads and 2-bit
// counters, instance 1 uses 4-cycle loads. An instruction-level model tracks
// what sits in EX/MEM/WB and how long a load has been in MEM.
module tb_pipe_hazard_unit;
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rn;
    logic [4:0] rm;
    logic       rw;
    logic       mr;
    logic       urn;
    logic       urm;
  } rec_t;

  localparam rec_t BUB = '{rd: 5'd31, rn: 5'd31, rm: 5'd31, rw: 1'b0, mr: 1'b0, urn: 1'b0, urm: 1'b0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rec_t cur[2];
  bit   cur_v[2];
  bit   hold[2];

  int   lat[2];
  int   cmax[2];
  rec_t m_ex[2], m_mem[2], m_wb[2];
  int   m_age[2], m_sc[2], m_fc[2];
  bit   m_init = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  pipe_hazard_if #(.REG_BITS(5), .CNT_W(2))  if0 ();
  pipe_hazard_if #(.REG_BITS(5), .CNT_W(16)) if1 ();

  pipe_hazard_unit #(.REG_BITS(5), .ZERO_REG(31), .LOAD_LAT(1), .CNT_W(2))
    u0 (.clk(clk), .Reset(rst), .hz(if0));
  pipe_hazard_unit #(.REG_BITS(5), .ZERO_REG(31), .LOAD_LAT(4), .CNT_W(16))
    u1 (.clk(clk), .Reset(rst), .hz(if1));

  assign if0.id_valid    = cur_v[0];
  assign if0.id_rn       = cur[0].rn;
  assign if0.id_rm       = cur[0].rm;
  assign if0.id_uses_rn  = cur[0].urn;
  assign if0.id_uses_rm  = cur[0].urm;
  assign if0.id_rd       = cur[0].rd;
  assign if0.id_regwrite = cur[0].rw;
  assign if0.id_memread  = cur[0].mr;
  assign if1.id_valid    = cur_v[1];
  assign if1.id_rn       = cur[1].rn;
  assign if1.id_rm       = cur[1].rm;
  assign if1.id_uses_rn  = cur[1].urn;
  assign if1.id_uses_rm  = cur[1].urm;
  assign if1.id_rd       = cur[1].rd;
  assign if1.id_regwrite = cur[1].rw;
  assign if1.id_memread  = cur[1].mr;

  logic       o_stall[2], o_freeze[2];
  logic [1:0] o_fa[2], o_fb[2];
  logic [4:0] o_ex[2], o_mem[2], o_wb[2];
  logic [31:0] o_sc[2], o_fc[2];
  assign o_stall[0] = if0.stall;   assign o_stall[1] = if1.stall;
  assign o_freeze[0] = if0.freeze; assign o_freeze[1] = if1.freeze;
  assign o_fa[0] = if0.fwd_a;      assign o_fa[1] = if1.fwd_a;
  assign o_fb[0] = if0.fwd_b;      assign o_fb[1] = if1.fwd_b;
  assign o_ex[0] = if0.ex_rd;      assign o_ex[1] = if1.ex_rd;
  assign o_mem[0] = if0.mem_rd;    assign o_mem[1] = if1.mem_rd;
  assign o_wb[0] = if0.wb_rd;      assign o_wb[1] = if1.wb_rd;
  assign o_sc[0] = {30'd0, if0.stall_cnt};
  assign o_sc[1] = {16'd0, if1.stall_cnt};
  assign o_fc[0] = {30'd0, if0.freeze_cnt};
  assign o_fc[1] = {16'd0, if1.freeze_cnt};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic rec_t ins(input int rd, input int rn, input int rm,
                               input bit urn, input bit urm, input bit rw, input bit mr);
    rec_t r;
    r.rd = 5'(rd); r.rn = 5'(rn); r.rm = 5'(rm);
    r.urn = urn; r.urm = urm; r.rw = rw; r.mr = mr;
    return r;
  endfunction

  // Reference rules, phrased per instruction record.
  function automatic bit mfreeze(input int k);
    return (lat[k] > 1) && m_mem[k].mr && (m_age[k] < lat[k] - 1);
  endfunction

  function automatic bit mstall(input int k);
    rec_t e;
    rec_t d;
    e = m_ex[k];
    d = cur[k];
    return !mfreeze(k) && cur_v[k] && e.mr && e.rw && (e.rd != 5'd31) &&
           ((d.urn && (d.rn == e.rd)) || (d.urm && (d.rm == e.rd)));
  endfunction

  function automatic int mfwd(input int k, input logic [4:0] src, input bit use_it);
    if (!use_it || src == 5'd31) return 0;
    if (m_mem[k].rw && !m_mem[k].mr && m_mem[k].rd == src) return 2;
    if (m_wb[k].rw && m_wb[k].rd == src) return 1;
    return 0;
  endfunction

  task automatic model_step(input int k);
    bit s;
    bit f;
    if (rst) begin
      m_ex[k] = BUB; m_mem[k] = BUB; m_wb[k] = BUB;
      m_age[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
    end else begin
      s = mstall(k);
      f = mfreeze(k);
      if (s && m_sc[k] < cmax[k]) m_sc[k]++;
      if (f && m_fc[k] < cmax[k]) m_fc[k]++;
      if (f) begin
        m_age[k]++;
      end else begin
        m_wb[k]  = m_mem[k];
        m_mem[k] = m_ex[k];
        m_ex[k]  = (s || !cur_v[k]) ? BUB : cur[k];
        m_age[k] = 0;
      end
    end
  endtask

  task automatic compare(input int k);
    chk($sformatf("stall%0d", k), 32'(o_stall[k]), 32'(mstall(k)));
    chk($sformatf("freeze%0d", k), 32'(o_freeze[k]), 32'(mfreeze(k)));
    chk($sformatf("fwd_a%0d", k), 32'(o_fa[k]), mfwd(k, m_ex[k].rn, m_ex[k].urn));
    chk($sformatf("fwd_b%0d", k), 32'(o_fb[k]), mfwd(k, m_ex[k].rm, m_ex[k].urm));
    chk($sformatf("ex_rd%0d", k), 32'(o_ex[k]), 32'(m_ex[k].rd));
    chk($sformatf("mem_rd%0d", k), 32'(o_mem[k]), 32'(m_mem[k].rd));
    chk($sformatf("wb_rd%0d", k), 32'(o_wb[k]), 32'(m_wb[k].rd));
    chk($sformatf("stall_cnt%0d", k), o_sc[k], m_sc[k]);
    chk($sformatf("freeze_cnt%0d", k), o_fc[k], m_fc[k]);
  endtask

  // One clock: check before the edge, advance the model on the edge.
  task automatic cycle();
    #1;
    for (int k = 0; k < 2; k++) begin
      if (m_init) compare(k);
      hold[k] = !rst && cur_v[k] && (mstall(k) || mfreeze(k));
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    if (rst) m_init = 1'b1;
    @(negedge clk);
  endtask

  task automatic put(input int k, input bit v, input rec_t r);
    cur_v[k] = v;
    cur[k]   = r;
  endtask

  task automatic idle(input int n);
    put(0, 1'b0, BUB);
    put(1, 1'b0, BUB);
    repeat (n) cycle();
  endtask

  function automatic logic [4:0] rnd_reg();
    case ($urandom_range(0, 4))
      0: return 5'd1;
      1: return 5'd2;
      2: return 5'd3;
      3: return 5'd4;
      default: return 5'd31;
    endcase
  endfunction

  function automatic rec_t rnd_ins();
    rec_t r;
    r.rd  = rnd_reg();
    r.rn  = rnd_reg();
    r.rm  = rnd_reg();
    r.mr  = ($urandom_range(0, 9) < 3);
    r.rw  = r.mr | ($urandom_range(0, 9) < 7);
    r.urn = 1'($urandom_range(0, 1));
    r.urm = 1'($urandom_range(0, 1));
    return r;
  endfunction

  initial begin
    lat[0] = 1; cmax[0] = 3;
    lat[1] = 4; cmax[1] = 65535;
    hold[0] = 1'b0; hold[1] = 1'b0;

    // Reset for two cycles with nothing valid in ID.
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("rst_stall", 32'(o_stall[k]), 0);
      chk("rst_freeze", 32'(o_freeze[k]), 0);
      chk("rst_fwd_a", 32'(o_fa[k]), 0);
      chk("rst_fwd_b", 32'(o_fb[k]), 0);
      chk("rst_ex_rd", 32'(o_ex[k]), 31);
      chk("rst_mem_rd", 32'(o_mem[k]), 31);
      chk("rst_wb_rd", 32'(o_wb[k]), 31);
      chk("rst_scnt", o_sc[k], 0);
      chk("rst_fcnt", o_fc[k], 0);
    end

    // ADD X1,X2,X3 ; SUB X4,X1,X5 -> MEM forward.
    put(0, 1'b1, ins(1, 2, 3, 1, 1, 1, 0)); cycle();
    put(0, 1'b1, ins(4, 1, 5, 1, 1, 1, 0)); cycle();
    chk("fwd_mem_a", 32'(o_fa[0]), 2);
    chk("fwd_mem_b", 32'(o_fb[0]), 0);
    idle(3);

    // One unrelated instruction in between -> WB forward.
    put(0, 1'b1, ins(1, 2, 3, 1, 1, 1, 0)); cycle();
    put(0, 1'b1, ins(6, 7, 8, 1, 1, 1, 0)); cycle();
    put(0, 1'b1, ins(4, 1, 5, 1, 1, 1, 0)); cycle();
    chk("fwd_wb_a", 32'(o_fa[0]), 1);
    idle(3);

    // XZR as destination is never forwarded.
    put(0, 1'b1, ins(31, 2, 3, 1, 1, 1, 0)); cycle();
    put(0, 1'b1, ins(4, 31, 5, 1, 1, 1, 0)); cycle();
    chk("fwd_xzr_a", 32'(o_fa[0]), 0);
    idle(3);

    // X1 in both MEM and WB -> MEM wins on both operands.
    put(0, 1'b1, ins(1, 2, 3, 1, 1, 1, 0)); cycle();
    put(0, 1'b1, ins(1, 2, 2, 1, 1, 1, 0)); cycle();
    put(0, 1'b1, ins(4, 1, 1, 1, 1, 1, 0)); cycle();
    chk("fwd_prio_a", 32'(o_fa[0]), 2);
    chk("fwd_prio_b", 32'(o_fb[0]), 2);
    idle(3);

    // LDUR X1 ; ADD X2,X1,X1 with single-cycle memory.
    put(0, 1'b1, ins(1, 2, 31, 1, 0, 1, 1)); cycle();
    put(0, 1'b1, ins(2, 1, 1, 1, 1, 1, 0)); #1;
    chk("lu_stall", 32'(o_stall[0]), 1);
    cycle();
    #1;
    chk("lu_stall_off", 32'(o_stall[0]), 0);
    chk("lu_bubble", 32'(o_ex[0]), 31);
    cycle();
    chk("lu_fwd_a", 32'(o_fa[0]), 1);
    chk("lu_fwd_b", 32'(o_fb[0]), 1);
    chk("lu_scnt", o_sc[0], 1);
    idle(3);

    // Single LDUR with 4-cycle memory: three frozen cycles, tags held.
    put(1, 1'b1, ins(1, 2, 31, 1, 0, 1, 1)); cycle();
    put(1, 1'b0, BUB); cycle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("frz_on%0d", i), 32'(o_freeze[1]), 1);
      chk($sformatf("frz_mem%0d", i), 32'(o_mem[1]), 1);
      chk($sformatf("frz_ex%0d", i), 32'(o_ex[1]), 31);
      chk($sformatf("frz_wb%0d", i), 32'(o_wb[1]), 31);
      cycle();
    end
    chk("frz_off", 32'(o_freeze[1]), 0);
    chk("frz_mem_last", 32'(o_mem[1]), 1);
    chk("frz_fcnt", o_fc[1], 3);
    cycle();
    chk("frz_wb_after", 32'(o_wb[1]), 1);
    chk("frz_mem_after", 32'(o_mem[1]), 31);
    idle(3);

    // Reset on the second frozen cycle aborts the wait.
    put(1, 1'b1, ins(1, 2, 31, 1, 0, 1, 1)); cycle();
    put(1, 1'b0, BUB); cycle();
    chk("abort_pre", 32'(o_freeze[1]), 1);
    cycle();
    rst = 1'b1; cycle(); rst = 1'b0;
    chk("abort_frz", 32'(o_freeze[1]), 0);
    chk("abort_ex", 32'(o_ex[1]), 31);
    chk("abort_mem", 32'(o_mem[1]), 31);
    chk("abort_wb", 32'(o_wb[1]), 31);
    chk("abort_fcnt", o_fc[1], 0);
    cycle();
    chk("abort_idle", 32'(o_freeze[1]), 0);

    // Five load-use stalls into a 2-bit counter.
    for (int i = 0; i < 5; i++) begin
      put(0, 1'b1, ins(1, 2, 31, 1, 0, 1, 1)); cycle();
      put(0, 1'b1, ins(2, 1, 1, 1, 1, 1, 0)); cycle();
      cycle();
    end
    idle(1);
    chk("sat_scnt", o_sc[0], 3);

    // Random instruction streams, held in ID while stalled or frozen.
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!hold[k]) begin
          cur_v[k] = ($urandom_range(0, 9) < 8);
          cur[k]   = rnd_ins();
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined LEGv8 processor, replacing the fixed 5-bit/2-source forwarding logic. It tracks destination tags through EX, MEM and WB and drives the ALU operand forwarding selects. It also generates the load-use bubble request and a pipeline freeze for data memories slower than one cycle. Saturating stall and freeze event counters are exposed for the processor debug outputs.

## Interface

Parameters:
- `REG_BITS`, default 5: register index width.
- `ZERO_REG`, default 31: index of XZR; it is never a forwarding or hazard source.
- `LOAD_LAT`, default 1: data-memory load latency in cycles, legal range 1..8.
- `CNT_W`, default 16: width of each event counter.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `Reset` in 1: synchronous active-high reset.
- `id_valid` in 1: the ID stage holds a real instruction.
- `id_rn`, `id_rm` in REG_BITS: source registers of the ID instruction.
- `id_uses_rn`, `id_uses_rm` in 1: each source is actually read.
- `id_rd` in REG_BITS: destination register of the ID instruction.
- `id_regwrite` in 1: the ID instruction writes `id_rd`.
- `id_memread` in 1: the ID instruction is a load (LDUR).
- `stall` out 1: hold PC and IF/ID, and insert a bubble into EX.
- `freeze` out 1: hold every pipeline register, including this block's own.
- `fwd_a`, `fwd_b` out 2: operand select for the EX instruction. 00 = register file, 01 = WB result, 10 = MEM result. 11 is never driven.
- `ex_rd`, `mem_rd`, `wb_rd` out REG_BITS: tracked destination tags.
- `stall_cnt`, `freeze_cnt` out CNT_W: saturating event counters.

## Operation

Internal tag stages:
- EX stage holds {rd, regwrite, memread, rn, rm, uses_rn, uses_rm}.
- MEM stage holds {rd, regwrite, memread}.
- WB stage holds {rd, regwrite}.
- A bubble is regwrite=0, memread=0, uses=0, with all register fields set to ZERO_REG.

Advance, on each edge when `freeze`=0:
- WB ← MEM.
- MEM ← EX.
- EX ← bubble if `stall` or !`id_valid`; otherwise EX ← ID inputs.

When `freeze`=1, all tag stages hold their values.

Load-use stall (combinational):
- `stall` = !`freeze` & `id_valid` & EX.memread & EX.regwrite & EX.rd≠ZERO_REG & ((`id_uses_rn` & `id_rn`=EX.rd) | (`id_uses_rm` & `id_rm`=EX.rd)).

Forwarding (combinational; `fwd_a` described, `fwd_b` identical using rm/uses_rm):
- 10 if EX.uses_rn & MEM.regwrite & !MEM.memread & MEM.rd≠ZERO_REG & MEM.rd=EX.rn.
- Else 01 if EX.uses_rn & WB.regwrite & WB.rd≠ZERO_REG & WB.rd=EX.rn.
- Else 00.
- MEM has priority over WB; the newest value wins.
- A load in MEM is never a forwarding source. The stall guarantees the consumer reaches EX only once the load is in WB.

Memory-wait FSM. States: IDLE, WAIT.
- `wait_cnt` is a 3-bit counter.
- IDLE → WAIT when the MEM stage holds a load (MEM.memread) and LOAD_LAT>1; `wait_cnt` loads 1.
- In WAIT: `freeze`=1 while `wait_cnt` < LOAD_LAT. `wait_cnt` increments each cycle. When `wait_cnt` = LOAD_LAT-1 the next edge sets `freeze`=0, the pipeline advances, and the FSM returns to IDLE.
- A load therefore occupies MEM for exactly LOAD_LAT cycles.
- With LOAD_LAT=1, `freeze` is constant 0.
- Back-to-back loads: each load entering MEM re-enters WAIT.

Counters:
- `stall_cnt` increments on each cycle with `stall`=1.
- `freeze_cnt` increments on each cycle with `freeze`=1.
- Both saturate at 2^CNT_W−1.

## Timing

- All tag stages, `wait_cnt`, FSM state and counters are registered.
- `stall`, `freeze`, `fwd_a` and `fwd_b` are combinational from registered state plus ID inputs; there is zero-cycle latency to the datapath.
- Reset (synchronous, `Reset`=1 at the edge) does the following, regardless of freeze or stall:
  - All stages become bubbles, so `ex_rd`, `mem_rd` and `wb_rd` read ZERO_REG.
  - FSM goes to IDLE, `wait_cnt` to 0, both counters to 0.
  - Consequently `stall`=0, `freeze`=0, `fwd_a`=`fwd_b`=00 from the first cycle after reset.
- Reset asserted mid-WAIT aborts the wait. The frozen load is discarded.
- `stall` and `freeze` are never both 1.
- A stall cycle advances EX → MEM normally; only ID is held.

## Test plan

- Reset held for 2 cycles, then released with `id_valid`=0 → all outputs 0 or 00, all tags ZERO_REG, counters 0.
- `ADD X1,X2,X3` then `SUB X4,X1,X5` → next cycle `fwd_a`=10. Insert one unrelated instruction between them instead → `fwd_a`=01. Use X31 as the destination → `fwd_a`=00.
- X1 written in both MEM and WB, consumer reads X1 in EX → `fwd_a`=10 (MEM wins).
- LOAD_LAT=1: `LDUR X1` followed by `ADD X2,X1,X1` → `stall`=1 for exactly 1 cycle, EX receives a bubble, then `fwd_a`=`fwd_b`=01 and `stall_cnt`=1.
- LOAD_LAT=4: a single LDUR → `freeze`=1 for 3 consecutive cycles once the load is in MEM, `freeze_cnt`=3, and all tags unchanged throughout the freeze.
- LOAD_LAT=4 with `Reset` pulsed on the 2nd freeze cycle → next cycle `freeze`=0, FSM IDLE, tags ZERO_REG. CNT_W=2 with 5 stalls → `stall_cnt` saturates at 3.
